// File: rtl/imem_loader.sv
// Byte-stream program loader for the 1024 x 16 instruction memory; holds the CPU until a full image is in.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module imem_loader #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int          CNT_W   = 11;
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_wr_fire;
    logic [15:0]        w_len;
    logic               w_len_bad;
    logic               w_last;

    logic               r_in_ready;
    logic               r_wr_en;
    logic [9:0]         r_wr_addr;
    logic [15:0]        r_wr_data;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;
    logic [7:0]         r_len_hi;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_hi;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         r_acc;
`endif

    assign w_accept  = in_valid && r_in_ready;
    assign w_len     = {r_len_hi, in_data};
    assign w_len_bad = (w_len == 16'd0) || (w_len > MAX_LEN);
    // Counter is one bit wider than the address so LEN = MAX_WORDS ends cleanly.
    assign w_last    = ((r_count + 11'd1) == r_len);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_wr_fire    = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_data == HEADER) w_state_next = S_LEN_HI;
                end
                S_LEN_HI:  w_state_next = S_LEN_LO;
                S_LEN_LO:  w_state_next = w_len_bad ? S_ERR : S_DATA_HI;
                S_DATA_HI: w_state_next = S_DATA_LO;
                S_DATA_LO: begin
                    w_wr_fire = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = w_last ? S_CHECK : S_DATA_HI;
`else
                    w_state_next = w_last ? S_DONE : S_DATA_HI;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK:   w_state_next = (in_data == r_acc) ? S_DONE : S_ERR;
`endif
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_len_hi   <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_hi       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_acc      <= '0;
`endif
        end else begin
            r_in_ready <= 1'b1;
            r_wr_en    <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= r_count[9:0];
                r_wr_data <= {r_hi, in_data};
                r_count   <= r_count + 11'd1;
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: r_len_hi <= in_data;
                    S_LEN_LO: begin
                        r_len   <= w_len[CNT_W-1:0];
                        r_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_acc   <= '0;
`endif
                    end
                    S_DATA_HI: begin
                        r_hi  <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_acc <= r_acc ^ in_data;
`endif
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_DATA_LO: r_acc <= r_acc ^ in_data;
`endif
                    default: ;
                endcase
            end
            // Status flags follow the next state so they move on the accepting edge.
            r_cpu_hold <= (w_state_next != S_DONE);
            r_done     <= (w_state_next == S_DONE);
            r_error    <= (w_state_next == S_ERR);
        end
    end

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames built from random word lists, expected writes taken from those lists.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  frame_q[$];
    logic [15:0] words_q[$];
    logic [25:0] exp_q[$];
    logic [25:0] wr_q[$];
    int          consec_wr = 0;
    logic        prev_wr = 1'b0;

    imem_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobe and flags strobes wider than one cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_q.push_back({wr_addr, wr_data});
            if (prev_wr) consec_wr++;
        end
        prev_wr = (wr_en === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic random_words(input int n);
        words_q.delete();
        repeat (n) words_q.push_back(16'($urandom));
    endtask

    // Appends a frame for words_q to frame_q and its expected writes to exp_q.
    task automatic build_frame(input bit good_sum);
        logic [7:0]  sum;
        logic [15:0] len;
        sum = 8'h00;
        len = 16'(words_q.size());
        frame_q.push_back(8'hA5);
        frame_q.push_back(len[15:8]);
        frame_q.push_back(len[7:0]);
        foreach (words_q[i]) begin
            frame_q.push_back(words_q[i][15:8]);
            frame_q.push_back(words_q[i][7:0]);
            sum = sum ^ words_q[i][15:8] ^ words_q[i][7:0];
            exp_q.push_back({10'(i), words_q[i]});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(good_sum ? sum : (sum ^ 8'h01));
`else
        if (!good_sum) $display("note: checksum disabled, frame sent without checksum");
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout got %b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int first, input int max_gap);
        for (int i = first; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (max_gap > 0 && i != frame_q.size() - 1)
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic check_status(input string name, input logic [2:0] exp_dhe);
        n_tests++;
        if ({done, cpu_hold, error} !== exp_dhe) begin
            n_fail++;
            $display("FAIL %s status {done,cpu_hold,error} got %b expected %b",
                     name, {done, cpu_hold, error}, exp_dhe);
        end
    endtask

    task automatic check_writes(input string name);
        repeat (2) @(negedge clk);
        n_tests++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count got %0d expected %0d", name, wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d] got addr=%0d data=%h expected addr=%0d data=%h",
                         name, i, wr_q[i][25:16], wr_q[i][15:0], exp_q[i][25:16], exp_q[i][15:0]);
            end
        end
        n_tests++;
        if (consec_wr != 0) begin
            n_fail++;
            $display("FAIL %s wr_en_width got %0d multi-cycle strobes expected 0", name, consec_wr);
        end
        wr_q.delete();
        exp_q.delete();
        frame_q.delete();
        consec_wr = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !==
            {1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s reset_outputs got rdy=%b wr=%b a=%0d d=%h hold=%b done=%b err=%b expected 0 0 0 0000 1 0 0",
                     name, in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release in_ready got %b expected 1", in_ready);
        end
        wr_q.delete();
    endtask

    task automatic test_good_frame();
        words_q = '{16'h1234, 16'hABCD};
        exp_q   = '{{10'd0, 16'h1234}, {10'd1, 16'hABCD}};
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h40);
`endif
        send_frame(0, 0);
        check_status("good_frame", 3'b100);
        check_writes("good_frame");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        exp_q   = '{{10'd0, 16'h1234}, {10'd1, 16'hABCD}};
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame(0, 0);
        check_status("bad_checksum", 3'b011);
        check_writes("bad_checksum");
        random_words($urandom_range(1, 16));
        build_frame(1'b1);
        send_frame(0, 0);
        check_status("recover_after_bad", 3'b100);
        check_writes("recover_after_bad");
    endtask
`endif

    task automatic test_illegal_len();
        frame_q = '{8'hA5, 8'h00, 8'h00};
        send_frame(0, 0);
        check_status("len_zero", 3'b011);
        check_writes("len_zero");
        frame_q = '{8'hA5, 8'h04, 8'h01};
        send_frame(0, 0);
        check_status("len_1025", 3'b011);
        check_writes("len_1025");
        random_words(1024);
        build_frame(1'b1);
        send_frame(0, 0);
        check_status("len_1024", 3'b100);
        repeat (2) @(negedge clk);
        n_tests++;
        if (wr_q.size() == 0 || wr_q[wr_q.size() - 1][25:16] !== 10'd1023) begin
            n_fail++;
            $display("FAIL len_1024 last_addr got %0d expected 1023",
                     (wr_q.size() == 0) ? -1 : int'(wr_q[wr_q.size() - 1][25:16]));
        end
        check_writes("len_1024");
    endtask

    task automatic test_noise_gaps();
        random_words($urandom_range(3, 8));
        build_frame(1'b1);
        send_byte(8'h00);
        send_byte(8'hFF);
        check_status("noise_ignored", 3'b100);
        send_byte(frame_q[0]);
        check_status("reload_header", 3'b010);
        send_frame(1, 3);
        check_status("gap_frame", 3'b100);
        check_writes("gap_frame");
    endtask

    task automatic test_reset_mid_frame();
        random_words(2);
        build_frame(1'b1);
        for (int i = 0; i < 4; i++) send_byte(frame_q[i]);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check_writes("mid_reset_no_write");
        send_byte(8'h34);
        check_status("mid_reset_idle", 3'b010);
        random_words($urandom_range(1, 6));
        build_frame(1'b1);
        send_frame(0, 0);
        check_status("after_reset_frame", 3'b100);
        check_writes("after_reset_frame");
    endtask

    task automatic test_back_to_back();
        random_words($urandom_range(1, 32));
        build_frame(1'b1);
        random_words($urandom_range(1, 32));
        build_frame(1'b1);
        send_frame(0, 0);
        check_status("back_to_back", 3'b100);
        check_writes("back_to_back");
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_illegal_len();
        test_noise_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
